regfile_wb_ctrl: RTL and testbench

Write-back controller for the 32x32 register file. Merges single-cycle ALU results and multi-cycle load results into the register file's single write port. Load results are buffered in a small FIFO, and a per-register pending-load scoreboard is kept for decode-stage hazard checks. Its registered outputs drive the register file's write enable, write address and write data, which the register file samples on the falling edge of `clk`.

---
 rtl/regfile_wb_ctrl.sv | 151 +++++++++++++++
 tb/tb_regfile_wb_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_ctrl.sv
// regfile_wb_ctrl: write-back controller for the register file's single write port.
// ALU results go straight through. Load results are queued in a small FIFO first.
// A per-register pending-load scoreboard supports decode-stage hazard checks.
//
// Ports:
//   i_clk, i_rst_n              clock, asynchronous active-low reset
//   i_alu_valid/addr/data       ALU result; o_alu_ready is low only in forced-FIFO cycles
//   i_mem_valid/addr/data       load result; o_mem_ready = !full
//   i_iss_valid, i_iss_addr     load issue, sets the pending bit of its destination
//   i_rs1_addr, i_rs2_addr      decode sources; o_rs1_busy/o_rs2_busy report pending loads
//   o_wb_en/addr/data           registered register-file write port
//   o_fifo_count                current load-FIFO occupancy
module regfile_wb_ctrl #(
   parameter int unsigned DEPTH      = 4,
   parameter int unsigned AW         = 5,
   parameter int unsigned DW         = 32,
   parameter int unsigned STARVE_MAX = 3
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_alu_valid,
   output logic                     o_alu_ready,
   input  logic [AW-1:0]            i_alu_addr,
   input  logic [DW-1:0]            i_alu_data,
   input  logic                     i_mem_valid,
   output logic                     o_mem_ready,
   input  logic [AW-1:0]            i_mem_addr,
   input  logic [DW-1:0]            i_mem_data,
   input  logic                     i_iss_valid,
   input  logic [AW-1:0]            i_iss_addr,
   input  logic [AW-1:0]            i_rs1_addr,
   input  logic [AW-1:0]            i_rs2_addr,
   output logic                     o_rs1_busy,
   output logic                     o_rs2_busy,
   output logic                     o_wb_en,
   output logic [AW-1:0]            o_wb_addr,
   output logic [DW-1:0]            o_wb_data,
   output logic [$clog2(DEPTH):0]   o_fifo_count
);

   localparam int unsigned PW   = $clog2(DEPTH);
   localparam int unsigned CW   = PW + 1;
   localparam int unsigned SW   = $clog2(STARVE_MAX + 1);
   localparam int unsigned NREG = 2 ** AW;

   logic [AW-1:0]   r_fifo_addr [DEPTH];
   logic [DW-1:0]   r_fifo_data [DEPTH];
   logic [PW-1:0]   r_wr_ptr;
   logic [PW-1:0]   r_rd_ptr;
   logic [CW-1:0]   r_count;
   logic [SW-1:0]   r_starve;
   logic [NREG-1:0] r_sb;

   logic            w_empty;
   logic            w_full;
   logic            w_forced;
   logic            w_push;
   logic            w_pop;
   logic            w_sel_alu;
   logic [AW-1:0]   w_head_addr;
   logic [DW-1:0]   w_head_data;
   logic [SW-1:0]   w_starve_d;
   logic [NREG-1:0] w_sb_d;

   assign w_empty     = (r_count == '0);
   assign w_full      = (r_count == CW'(DEPTH));
   assign w_head_addr = r_fifo_addr[r_rd_ptr];
   assign w_head_data = r_fifo_data[r_rd_ptr];

   // Forced mode: the FIFO has lost STARVE_MAX arbitrations in a row and takes the port.
   assign w_forced  = (r_starve == SW'(STARVE_MAX)) && !w_empty;
   assign w_sel_alu = !w_forced && i_alu_valid;
   assign w_pop     = !w_empty && (w_forced || !i_alu_valid);
   // No push-through when full: a same-cycle pop does not free the slot early.
   assign w_push    = i_mem_valid && !w_full;

   assign o_alu_ready  = !w_forced;
   assign o_mem_ready  = !w_full;
   assign o_fifo_count = r_count;
   assign o_rs1_busy   = r_sb[i_rs1_addr];
   assign o_rs2_busy   = r_sb[i_rs2_addr];

   always_comb begin
      w_starve_d = r_starve;
      if (w_pop || w_empty) begin
         w_starve_d = '0;
      end else if (w_sel_alu && (r_starve != SW'(STARVE_MAX))) begin
         w_starve_d = r_starve + 1'b1;
      end
   end

   // Clear before set so a same-cycle re-issue of the popped register stays pending.
   always_comb begin
      w_sb_d = r_sb;
      if (w_pop) begin
         w_sb_d[w_head_addr] = 1'b0;
      end
      if (i_iss_valid) begin
         w_sb_d[i_iss_addr] = 1'b1;
      end
      w_sb_d[0] = 1'b0;
   end

   // FIFO storage carries no reset; occupancy is tracked by the pointers and count.
   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_fifo_addr[r_wr_ptr] <= i_mem_addr;
         r_fifo_data[r_wr_ptr] <= i_mem_data;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_starve <= '0;
         r_sb     <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         r_count  <= r_count + CW'(w_push) - CW'(w_pop);
         r_starve <= w_starve_d;
         r_sb     <= w_sb_d;
      end
   end

   // Register 0 is never written: the selection still updates address and data.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_wb_en   <= 1'b0;
         o_wb_addr <= '0;
         o_wb_data <= '0;
      end else if (w_sel_alu) begin
         o_wb_en   <= (i_alu_addr != '0);
         o_wb_addr <= i_alu_addr;
         o_wb_data <= i_alu_data;
      end else if (w_pop) begin
         o_wb_en   <= (w_head_addr != '0);
         o_wb_addr <= w_head_addr;
         o_wb_data <= w_head_data;
      end else begin
         o_wb_en   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed bench for regfile_wb_ctrl. Expected register-file writes are queued as stimulus is
// issued; a negedge monitor compares every emitted write against the queue head.
module tb_regfile_wb_ctrl;

   typedef struct packed {
      logic [4:0]  addr;
      logic [31:0] data;
   } wb_t;

   logic        clk;
   logic        rst_n;
   logic        alu_valid;
   logic        alu_ready;
   logic [4:0]  alu_addr;
   logic [31:0] alu_data;
   logic        mem_valid;
   logic        mem_ready;
   logic [4:0]  mem_addr;
   logic [31:0] mem_data;
   logic        iss_valid;
   logic [4:0]  iss_addr;
   logic [4:0]  rs1_addr;
   logic [4:0]  rs2_addr;
   logic        rs1_busy;
   logic        rs2_busy;
   logic        wb_en;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic [2:0]  fifo_count;

   int  n_checks = 0;
   int  n_errors = 0;
   wb_t exp_q[$];

   regfile_wb_ctrl dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_alu_valid  (alu_valid),
      .o_alu_ready  (alu_ready),
      .i_alu_addr   (alu_addr),
      .i_alu_data   (alu_data),
      .i_mem_valid  (mem_valid),
      .o_mem_ready  (mem_ready),
      .i_mem_addr   (mem_addr),
      .i_mem_data   (mem_data),
      .i_iss_valid  (iss_valid),
      .i_iss_addr   (iss_addr),
      .i_rs1_addr   (rs1_addr),
      .i_rs2_addr   (rs2_addr),
      .o_rs1_busy   (rs1_busy),
      .o_rs2_busy   (rs2_busy),
      .o_wb_en      (wb_en),
      .o_wb_addr    (wb_addr),
      .o_wb_data    (wb_data),
      .o_fifo_count (fifo_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void check(input string name, input logic [31:0] act,
                                 input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endfunction

   function automatic void push_exp(input logic [4:0] a, input logic [31:0] d);
      wb_t e;
      e.addr = a;
      e.data = d;
      exp_q.push_back(e);
   endfunction

   // Register file samples on the falling edge, so the monitor does too.
   always @(negedge clk) begin
      wb_t e;
      if (wb_en === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_write: got addr %0d data 0x%08h expected no write",
                     wb_addr, wb_data);
         end else begin
            e = exp_q.pop_front();
            check("sb_wb_addr", 32'(wb_addr), 32'(e.addr));
            check("sb_wb_data", wb_data, e.data);
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      alu_valid = 1'b0;
      alu_addr  = '0;
      alu_data  = '0;
      mem_valid = 1'b0;
      mem_addr  = '0;
      mem_data  = '0;
      iss_valid = 1'b0;
      iss_addr  = '0;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      int k;
      int j;
      int t;
      logic acc_a;
      logic acc_m;
      rst_n    = 1'b0;
      rs1_addr = '0;
      rs2_addr = '0;
      idle_inputs();
      #2;
      check("rst_wb_en", 32'(wb_en), 32'd0);
      check("rst_wb_addr", 32'(wb_addr), 32'd0);
      check("rst_wb_data", wb_data, 32'd0);
      check("rst_alu_ready", 32'(alu_ready), 32'd1);
      check("rst_mem_ready", 32'(mem_ready), 32'd1);
      check("rst_fifo_count", 32'(fifo_count), 32'd0);
      check("rst_rs1_busy", 32'(rs1_busy), 32'd0);
      cyc();
      rst_n = 1'b1;
      cyc();

      // ALU single-cycle path
      alu_valid = 1'b1;
      alu_addr  = 5'd5;
      alu_data  = 32'hA5A5_0001;
      push_exp(5'd5, 32'hA5A5_0001);
      #1;
      check("alu_ready_hi", 32'(alu_ready), 32'd1);
      cyc();
      idle_inputs();
      check("alu_wb_en", 32'(wb_en), 32'd1);
      check("alu_wb_addr", 32'(wb_addr), 32'd5);
      check("alu_wb_data", wb_data, 32'hA5A5_0001);
      check("idle_alu_ready", 32'(alu_ready), 32'd1);
      cyc();
      check("idle_wb_en", 32'(wb_en), 32'd0);
      check("idle_wb_hold", wb_data, 32'hA5A5_0001);

      // Register 0 filter, ALU then load
      alu_valid = 1'b1;
      alu_addr  = 5'd0;
      alu_data  = 32'hFFFF_FFFF;
      cyc();
      idle_inputs();
      check("r0_alu_wb_en", 32'(wb_en), 32'd0);
      check("r0_alu_wb_data", wb_data, 32'hFFFF_FFFF);
      mem_valid = 1'b1;
      mem_addr  = 5'd0;
      mem_data  = 32'h0000_1234;
      cyc();
      idle_inputs();
      check("r0_ld_count1", 32'(fifo_count), 32'd1);
      cyc();
      check("r0_ld_count0", 32'(fifo_count), 32'd0);
      check("r0_ld_wb_en", 32'(wb_en), 32'd0);
      check("r0_ld_wb_data", wb_data, 32'h0000_1234);

      // Scoreboard with load latency
      rs1_addr  = 5'd7;
      rs2_addr  = 5'd7;
      iss_valid = 1'b1;
      iss_addr  = 5'd7;
      #1;
      check("sb_no_bypass", 32'(rs1_busy), 32'd0);
      cyc();
      idle_inputs();
      check("sb_busy_set", 32'(rs1_busy), 32'd1);
      check("sb_busy_rs2", 32'(rs2_busy), 32'd1);
      mem_valid = 1'b1;
      mem_addr  = 5'd7;
      mem_data  = 32'hDEAD_0007;
      push_exp(5'd7, 32'hDEAD_0007);
      cyc();
      idle_inputs();
      check("ld_count1", 32'(fifo_count), 32'd1);
      check("sb_busy_pop_cyc", 32'(rs1_busy), 32'd1);
      cyc();
      check("ld_wb_en", 32'(wb_en), 32'd1);
      check("ld_wb_addr", 32'(wb_addr), 32'd7);
      check("sb_busy_clr", 32'(rs1_busy), 32'd0);
      check("ld_count0", 32'(fifo_count), 32'd0);

      // Re-issue of 7 during its pop cycle keeps it pending
      iss_valid = 1'b1;
      iss_addr  = 5'd7;
      cyc();
      idle_inputs();
      mem_valid = 1'b1;
      mem_addr  = 5'd7;
      mem_data  = 32'h0000_0077;
      push_exp(5'd7, 32'h0000_0077);
      cyc();
      idle_inputs();
      iss_valid = 1'b1;
      iss_addr  = 5'd7;
      cyc();
      idle_inputs();
      check("sb_set_wins", 32'(rs1_busy), 32'd1);
      mem_valid = 1'b1;
      mem_addr  = 5'd7;
      mem_data  = 32'h0000_0078;
      push_exp(5'd7, 32'h0000_0078);
      cyc();
      idle_inputs();
      cyc();
      check("sb_reissue_clr", 32'(rs1_busy), 32'd0);
      rs2_addr  = 5'd0;
      iss_valid = 1'b1;
      iss_addr  = 5'd0;
      cyc();
      idle_inputs();
      check("sb_r0_never_busy", 32'(rs2_busy), 32'd0);

      // Starvation guard: ALU wins cycles 0..3, load forced in cycle 4
      for (int i = 0; i < 4; i++) push_exp(5'd1, 32'h100 + 32'(i));
      push_exp(5'd9, 32'h900);
      push_exp(5'd1, 32'h104);
      for (int i = 0; i < 4; i++) begin
         alu_valid = 1'b1;
         alu_addr  = 5'd1;
         alu_data  = 32'h100 + 32'(i);
         mem_valid = (i == 0);
         mem_addr  = 5'd9;
         mem_data  = 32'h900;
         #1;
         check("starve_alu_ready", 32'(alu_ready), 32'd1);
         cyc();
      end
      mem_valid = 1'b0;
      alu_data  = 32'h104;
      #1;
      check("starve_forced", 32'(alu_ready), 32'd0);
      cyc();
      check("starve_ld_wb_addr", 32'(wb_addr), 32'd9);
      check("starve_ld_wb_data", wb_data, 32'h900);
      check("starve_released", 32'(alu_ready), 32'd1);
      cyc();
      idle_inputs();
      check("starve_alu_after", wb_data, 32'h104);

      // FIFO fill with ALU held busy; fifth load waits for a slot
      for (int i = 0; i < 4; i++) push_exp(5'd2, 32'h200 + 32'(i));
      push_exp(5'd10, 32'hC00);
      push_exp(5'd2, 32'h204);
      for (int i = 1; i < 5; i++) push_exp(5'(10 + i), 32'hC00 + 32'(i));
      k = 0;
      j = 0;
      t = 0;
      while ((k < 5 || j < 5) && t < 20) begin
         alu_valid = (k < 5);
         alu_addr  = 5'd2;
         alu_data  = 32'h200 + 32'(k);
         mem_valid = (j < 5);
         mem_addr  = 5'(10 + j);
         mem_data  = 32'hC00 + 32'(j);
         #1;
         if (t == 4) begin
            check("fill_count_full", 32'(fifo_count), 32'd4);
            check("fill_mem_ready_lo", 32'(mem_ready), 32'd0);
            check("fill_forced", 32'(alu_ready), 32'd0);
         end
         if (t == 5) begin
            check("fill_count_after_pop", 32'(fifo_count), 32'd3);
            check("fill_mem_ready_hi", 32'(mem_ready), 32'd1);
         end
         acc_a = alu_valid & alu_ready;
         acc_m = mem_valid & mem_ready;
         cyc();
         if (acc_a) k++;
         if (acc_m) j++;
         t++;
      end
      idle_inputs();
      check("fill_cycles", 32'(t), 32'd6);
      for (int i = 0; i < 20 && fifo_count != 0; i++) cyc();
      check("fill_drained", 32'(fifo_count), 32'd0);
      cyc();

      // Async reset with three queued loads
      rs1_addr = 5'd12;
      push_exp(5'd3, 32'h300);
      push_exp(5'd3, 32'h301);
      for (int i = 0; i < 3; i++) begin
         alu_valid = 1'b1;
         alu_addr  = 5'd3;
         alu_data  = 32'h300 + 32'(i);
         mem_valid = 1'b1;
         mem_addr  = 5'(12 + i);
         mem_data  = 32'hD00 + 32'(i);
         iss_valid = (i == 0);
         iss_addr  = 5'd12;
         cyc();
      end
      idle_inputs();
      #1;
      check("pre_rst_count", 32'(fifo_count), 32'd3);
      check("pre_rst_busy", 32'(rs1_busy), 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      check("async_rst_count", 32'(fifo_count), 32'd0);
      check("async_rst_wb_en", 32'(wb_en), 32'd0);
      check("async_rst_busy", 32'(rs1_busy), 32'd0);
      check("async_rst_mem_ready", 32'(mem_ready), 32'd1);
      cyc();
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) cyc();
      check("post_rst_count", 32'(fifo_count), 32'd0);
      check("exp_q_empty", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
